// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative 1-bit/cycle shifts,
// valid/ready handshakes on both sides and a synchronous flush.
module alu_exec_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      opcode,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_SLT  = 4'h3;
   localparam logic [3:0] OP_SLTU = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_SRL  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [XLEN-1:0]      r_result;
   logic                 r_zero;
   logic                 r_illegal;
   logic [SHAMT_W-1:0]   r_count;
   logic [3:0]           r_op;

   logic                 w_accept;
   logic                 w_is_shift;
   logic [SHAMT_W-1:0]   w_shamt;
   logic [XLEN-1:0]      w_alu;
   logic                 w_alu_illegal;
   logic [XLEN-1:0]      w_shift_nxt;

   assign in_ready   = (r_state == S_IDLE) && !flush && !RST;
   assign w_accept   = in_valid && in_ready;
   assign w_shamt    = operand_b[SHAMT_W-1:0];
   assign w_is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);

   assign out_valid  = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   assign result     = r_result;
   assign zero       = r_zero;
   assign illegal    = r_illegal;

   // Single-cycle result; shift opcodes land here only with a zero shift amount
   always_comb begin
      w_alu         = '0;
      w_alu_illegal = 1'b0;
      case (opcode)
         OP_ADD:  w_alu = operand_a + operand_b;
         OP_SUB:  w_alu = operand_a - operand_b;
         OP_SLT:  w_alu = XLEN'($signed(operand_a) < $signed(operand_b));
         OP_SLTU: w_alu = XLEN'(operand_a < operand_b);
         OP_OR:   w_alu = operand_a | operand_b;
         OP_XOR:  w_alu = operand_a ^ operand_b;
         OP_AND:  w_alu = operand_a & operand_b;
         OP_SLL, OP_SRL, OP_SRA: w_alu = operand_a;
         default: w_alu_illegal = 1'b1;
      endcase
   end

   // One-bit shift step; SRA replicates the working MSB, which still holds the original sign
   always_comb begin
      w_shift_nxt = r_result;
      case (r_op)
         OP_SLL:  w_shift_nxt = {r_result[XLEN-2:0], 1'b0};
         OP_SRL:  w_shift_nxt = {1'b0, r_result[XLEN-1:1]};
         default: w_shift_nxt = {r_result[XLEN-1], r_result[XLEN-1:1]};
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_shift && (w_shamt != '0)) w_state_nxt = S_SHIFT;
               else                               w_state_nxt = S_DONE;
            end
         end
         S_SHIFT: if (r_count == SHAMT_W'(1)) w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Result register doubles as the shift working register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
         r_count   <= '0;
         r_op      <= '0;
      end else if (!flush) begin
         if (w_accept) begin
            r_op <= opcode;
            if (w_is_shift && (w_shamt != '0)) begin
               r_result  <= operand_a;
               r_count   <= w_shamt;
               r_illegal <= 1'b0;
            end else begin
               r_result  <= w_alu;
               r_zero    <= (w_alu == '0);
               r_illegal <= w_alu_illegal;
            end
         end else if (r_state == S_SHIFT) begin
            r_result <= w_shift_nxt;
            r_count  <= r_count - SHAMT_W'(1);
            if (r_count == SHAMT_W'(1)) r_zero <= (w_shift_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake/flush/reset
// sequences and randomized ops against a behavioural model.
module tb_alu_exec_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  opcode = 4'h0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   alu_exec_unit dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal), .busy(busy)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on whole operands; latency from the shift distance
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(b % 32);
      ill = 1'b0;
      lat = 1;
      case (op)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: begin r = a << sh; lat = 1 + sh; end
         4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4: r = (a < b) ? 32'd1 : 32'd0;
         4'd5: r = a | b;
         4'd6: r = a ^ b;
         4'd7: r = a & b;
         4'd8: begin r = a >> sh; lat = 1 + sh; end
         4'd9: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
   endfunction

   // Issue one op, measure cycles to out_valid, then complete the handshake after `hold` cycles
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output logic z,
                         output logic ill, output int lat);
      @(negedge CLK);
      chk("in_ready_before_issue", 32'(in_ready), 32'd1);
      opcode = op; operand_a = a; operand_b = b; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      lat = -1;
      res = '0; z = 1'b0; ill = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge CLK);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      if (lat > 0) begin
         res = result; z = zero; ill = illegal;
         repeat (hold) @(negedge CLK);
         out_ready = 1'b1;
         @(posedge CLK);
         #1 out_ready = 1'b0;
      end
   endtask

   logic [31:0] r_res, m_res;
   logic        r_z, r_ill, m_ill;
   int          r_lat, m_lat;
   int          seen;

   initial begin
      vecs[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'h1, 32'h5,         32'h5,        32'h0,         1'b1, 1'b0, 1};
      vecs[2]  = '{4'h3, 32'hFFFF_FFFF, 32'h1,        32'h1,         1'b0, 1'b0, 1};
      vecs[3]  = '{4'h4, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1'b0, 1};
      vecs[4]  = '{4'h7, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'h5, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1};
      vecs[6]  = '{4'h6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 1};
      vecs[7]  = '{4'h9, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 1'b0, 32};
      vecs[8]  = '{4'h2, 32'h1234_5678, 32'd0,        32'h1234_5678, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'hC, 32'h5,         32'h3,        32'h0,         1'b1, 1'b1, 1};
      vecs[10] = '{4'h8, 32'h8000_0000, 32'h24,       32'h0800_0000, 1'b0, 1'b0, 5};
      vecs[11] = '{4'h2, 32'h1,         32'd31,       32'h8000_0000, 1'b0, 1'b0, 32};
      vecs[12] = '{4'h9, 32'h4000_0000, 32'd3,        32'h0800_0000, 1'b0, 1'b0, 4};

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r_res, r_z, r_ill, r_lat);
         chk($sformatf("vec%0d_lat", i), 32'(r_lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_result", i), r_res, vecs[i].res);
         chk($sformatf("vec%0d_zero", i), 32'(r_z), 32'(vecs[i].z));
         chk($sformatf("vec%0d_illegal", i), 32'(r_ill), 32'(vecs[i].ill));
      end

      // Backpressure: DONE held 5 cycles, extra in_valid must be ignored
      @(negedge CLK);
      opcode = 4'h5; operand_a = 32'h1; operand_b = 32'h2; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      @(negedge CLK);
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      opcode = 4'h0; operand_a = 32'h10; operand_b = 32'h10; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", result, 32'h3);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK);
      #1 out_ready = 1'b0;
      @(negedge CLK);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_busy", 32'(busy), 32'd0);

      // Flush during SHIFT at cycle N+7; the in_valid in the flush cycle must be dropped
      @(negedge CLK);
      opcode = 4'h8; operand_a = 32'hFFFF_FFFF; operand_b = 32'd20; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge CLK);
      @(negedge CLK);
      chk("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      opcode = 4'h0; operand_a = 32'h1; operand_b = 32'h1; in_valid = 1'b1;
      #1 chk("flush_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge CLK);
      #1 begin flush = 1'b0; in_valid = 1'b0; end
      @(negedge CLK);
      chk("flush_in_ready_n8", 32'(in_ready), 32'd1);
      chk("flush_busy_n8", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (out_valid) seen = 1;
      end
      chk("flush_no_out_valid", 32'(seen), 32'd0);

      // Reset while shifting, with zero/illegal left set by a prior illegal op
      run_op(4'hF, 32'h1, 32'h1, 0, r_res, r_z, r_ill, r_lat);
      chk("pre_rst_illegal", 32'(r_ill), 32'd1);
      @(negedge CLK);
      opcode = 4'h2; operand_a = 32'h1; operand_b = 32'd10; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_mid_busy_before", 32'(busy), 32'd1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_zero", 32'(zero), 32'd0);
      chk("rst_mid_illegal", 32'(illegal), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_mid_in_ready_after", 32'(in_ready), 32'd1);

      // Randomized ops against the model
      for (int i = 0; i < 150; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = $urandom();
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
         if (i % 7 == 0) a = 32'h8000_0000 | $urandom();
         model(op, a, b, m_res, m_ill, m_lat);
         run_op(op, a, b, int'($urandom_range(0, 2)), r_res, r_z, r_ill, r_lat);
         chk($sformatf("rnd%0d_op%0h_lat", i, op), 32'(r_lat), 32'(m_lat));
         chk($sformatf("rnd%0d_op%0h_result", i, op), r_res, m_res);
         chk($sformatf("rnd%0d_op%0h_zero", i, op), 32'(r_z), 32'(m_res == 32'd0));
         chk($sformatf("rnd%0d_op%0h_illegal", i, op), 32'(r_ill), 32'(m_ill));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
